nios_mtl_sysid_ctrl: RTL and testbench

- Sequencer and arbiter in front of the Qsys system-ID slave: 1-bit address, 32-bit combinational readdata; word 0 = system ID, word 1 = build timestamp.
- After reset, or on request, reads both words and compares them with build-time expectations. Reports pass/fail, with bounded retry.
- Gives a host Avalon-MM master shared access to the same slave. The checker always has priority.

---
 rtl/nios_mtl_sysid_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_nios_mtl_sysid_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_mtl_sysid_ctrl.sv
// nios_mtl_sysid_ctrl: boot-time sequencer and arbiter in front of the Qsys
// system-ID slave. Reads ID and timestamp words, compares them with build-time
// expectations with bounded retry, then hands the slave to a host Avalon master.
// Optional feature macro: SYSID_CTRL_IRQ_EN adds an irq output raised on failure.
module nios_mtl_sysid_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1459342059,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        m_address,
  input  logic        m_read,
  output logic [31:0] m_readdata,
  output logic        m_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [3:0]  retry_cnt,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
`ifdef SYSID_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned WAIT_W   = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned HOLD     = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(READ_LATENCY);
  localparam logic [WAIT_W-1:0] HOLD_CNT  = WAIT_W'(HOLD);
  localparam logic [CNT_W-1:0]  RETRY_MAX = CNT_W'(MAX_RETRY);
  localparam logic              HAS_LAT   = (READ_LATENCY != 0);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] r_hcnt;
  logic              r_read_d;
  logic              r_addr_d;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic [CNT_W-1:0]  r_retry;
  logic [31:0]       r_id_word;
  logic [31:0]       r_ts_word;
  logic              r_irq;
  logic              w_rd_active;
  logic              w_rd_last;
  logic              w_match;
  logic              w_can_retry;
  logic              w_host_evt;

  assign w_rd_active = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign w_rd_last   = (r_wait == LAST_WAIT);
  assign w_match     = (r_id_word == EXPECTED_ID) && (r_ts_word == EXPECTED_TS);
  assign w_can_retry = (r_retry < RETRY_MAX);

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;
  assign id_word   = r_id_word;
  assign ts_word   = r_ts_word;
`ifdef SYSID_CTRL_IRQ_EN
  assign irq       = r_irq;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_BOOT;
    else          r_state <= w_next;
  end

  // Next-state logic: read both words, compare, retry or finish
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:  w_next = S_RD_ID;
      S_RD_ID: if (w_rd_last) w_next = S_RD_TS;
      S_RD_TS: if (w_rd_last) w_next = S_CHECK;
      S_CHECK: begin
        if (w_match)          w_next = S_DONE;
        else if (w_can_retry) w_next = S_RD_ID;
        else                  w_next = S_DONE;
      end
      S_DONE:  if (start) w_next = S_RD_ID;
      default: w_next = S_BOOT;
    endcase
  end

  // Slave ownership and host stall; a start in DONE pre-empts the host
  always_comb begin
    sid_address   = 1'b0;
    m_readdata    = '0;
    m_waitrequest = 1'b1;
    w_host_evt    = 1'b0;
    case (r_state)
      S_RD_TS: sid_address = 1'b1;
      S_DONE: begin
        sid_address = m_address;
        if (!start) begin
          m_readdata    = sid_readdata;
          w_host_evt    = m_read && (!r_read_d || (m_address != r_addr_d));
          m_waitrequest = HAS_LAT && (w_host_evt || (r_hcnt != '0));
        end
      end
      default: ;
    endcase
  end

  // Wait counter, word capture, result flags and host-latency tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait    <= '0;
      r_hcnt    <= '0;
      r_read_d  <= 1'b0;
      r_addr_d  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_retry   <= '0;
      r_id_word <= '0;
      r_ts_word <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RD_ID) || (w_next == S_RD_TS) || (w_next == S_CHECK);
      r_done <= (w_next == S_DONE);

      if (w_rd_active && !w_rd_last) r_wait <= r_wait + WAIT_W'(1);
      else                           r_wait <= '0;

      if ((r_state == S_RD_ID) && w_rd_last) r_id_word <= sid_readdata;
      if ((r_state == S_RD_TS) && w_rd_last) r_ts_word <= sid_readdata;

      case (r_state)
        S_CHECK: begin
          if (w_match)          r_pass  <= 1'b1;
          else if (w_can_retry) r_retry <= r_retry + CNT_W'(1);
          else begin
            r_fail <= 1'b1;
            r_irq  <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_retry <= '0;
            r_irq   <= 1'b0;
          end
        end
        default: ;
      endcase

      r_read_d <= (r_state == S_DONE) && m_read;
      r_addr_d <= m_address;
      if (r_state != S_DONE)  r_hcnt <= '0;
      else if (w_host_evt)    r_hcnt <= HOLD_CNT;
      else if (r_hcnt != '0)  r_hcnt <= r_hcnt - WAIT_W'(1);
    end
  end

`ifndef SYSID_CTRL_IRQ_EN
  logic w_irq_unused;
  assign w_irq_unused = r_irq;
`endif

endmodule

// File: tb/tb_nios_mtl_sysid_ctrl.sv
// Bench for nios_mtl_sysid_ctrl: a READ_LATENCY=0 instance checked every cycle
// against a pass-count timeline model plus directed literals, and a
// READ_LATENCY=2 instance checked with directed literals only.
module tb_nios_mtl_sysid_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1459342059;
  localparam int          MAXR   = 3;
  localparam int          PL0    = 3;   // cycles per full pass at READ_LATENCY=0

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  logic        start0 = 1'b0, m_read0 = 1'b0, m_addr0 = 1'b0;
  logic        sid_address0, m_waitrequest0, busy0, done0, pass0, fail0;
  logic [31:0] rd0, m_readdata0, id_word0, ts_word0;
  logic [3:0]  retry0;

  logic        start2 = 1'b0, m_read2 = 1'b0, m_addr2 = 1'b0;
  logic        sid_address2, m_waitrequest2, busy2, done2, pass2, fail2;
  logic [31:0] rd2, m_readdata2, id_word2, ts_word2;
  logic [3:0]  retry2;
  logic        a1 = 1'b0, a2 = 1'b0;
`ifdef SYSID_CTRL_IRQ_EN
  logic        irq0, irq2;
`endif

  bit bad_id = 1'b0, bad_ts_first = 1'b0;
  int cyc = 0, n0 = 0, m_P = 1, cur_k;
  bit m_ok = 1'b1, rn_d = 1'b0;
  logic [31:0] m_id = EXP_ID, m_ts = EXP_TS;
  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  nios_mtl_sysid_ctrl #(.READ_LATENCY(0), .MAX_RETRY(MAXR)) dut0 (
    .clock(clk), .reset_n(reset_n), .start(start0),
    .sid_address(sid_address0), .sid_readdata(rd0),
    .m_address(m_addr0), .m_read(m_read0), .m_readdata(m_readdata0),
    .m_waitrequest(m_waitrequest0), .busy(busy0), .done(done0),
    .pass(pass0), .fail(fail0), .retry_cnt(retry0),
    .id_word(id_word0), .ts_word(ts_word0)
`ifdef SYSID_CTRL_IRQ_EN
    , .irq(irq0)
`endif
  );

  nios_mtl_sysid_ctrl #(.READ_LATENCY(2), .MAX_RETRY(MAXR)) dut2 (
    .clock(clk), .reset_n(reset_n), .start(start2),
    .sid_address(sid_address2), .sid_readdata(rd2),
    .m_address(m_addr2), .m_read(m_read2), .m_readdata(m_readdata2),
    .m_waitrequest(m_waitrequest2), .busy(busy2), .done(done2),
    .pass(pass2), .fail(fail2), .retry_cnt(retry2),
    .id_word(id_word2), .ts_word(ts_word2)
`ifdef SYSID_CTRL_IRQ_EN
    , .irq(irq2)
`endif
  );

  // Slave word as a function of address and which check pass is running
  function automatic logic [31:0] slv_word(input logic a, input int k);
    if (!a) return bad_id ? 32'h0000_DEAD : EXP_ID;
    return (bad_ts_first && k == 0) ? 32'h1234_5678 : EXP_TS;
  endfunction

  // Number of passes a check takes and whether it ends in pass
  function automatic int passes(output bit ok);
    for (int k = 0; k <= MAXR; k++) begin
      if (slv_word(1'b0, k) == EXP_ID && slv_word(1'b1, k) == EXP_TS) begin
        ok = 1'b1;
        return k + 1;
      end
    end
    ok = 1'b0;
    return MAXR + 1;
  endfunction

  // Zero-latency slave for dut0
  always_comb begin
    cur_k = (cyc >= n0) ? (cyc - n0) / PL0 : 0;
    if (!sid_address0) rd0 = bad_id ? 32'h0000_DEAD : EXP_ID;
    else               rd0 = (bad_ts_first && cur_k == 0) ? 32'h1234_5678 : EXP_TS;
  end

  // Two-cycle-latency slave for dut2
  always @(posedge clk) begin
    a1 <= sid_address2;
    a2 <= a1;
  end
  assign rd2 = a2 ? EXP_TS : EXP_ID;

  // Model timeline: launch on first edge after reset release or a start seen while done
  always @(posedge clk) begin
    int  t_p;
    bit  t_ok;
    cyc  <= cyc + 1;
    rn_d <= reset_n;
    if (reset_n && (!rn_d || (start0 && (cyc - n0) >= m_P * PL0))) begin
      t_p  = passes(t_ok);
      n0   <= cyc + 1;
      m_P  <= t_p;
      m_ok <= t_ok;
      m_id <= slv_word(1'b0, t_p - 1);
      m_ts <= slv_word(1'b1, t_p - 1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Every-cycle compare of dut0 against the model
  always @(negedge clk) begin
    int e, ph, r;
    bit dn;
    if (!reset_n || !rn_d) begin
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_fail", fail0, 0);
      chk("rst_retry", retry0, 0);
      chk("rst_id", id_word0, 0);
      chk("rst_ts", ts_word0, 0);
      chk("rst_addr", sid_address0, 0);
      chk("rst_wait", m_waitrequest0, 1);
    end else begin
      e  = cyc - n0;
      dn = (e >= m_P * PL0);
      r  = e / PL0;
      if (r > m_P - 1) r = m_P - 1;
      chk("m_busy", busy0, !dn);
      chk("m_done", done0, dn);
      chk("m_pass", pass0, dn && m_ok);
      chk("m_fail", fail0, dn && !m_ok);
      chk("m_retry", retry0, r);
      if (!dn) begin
        ph = e % PL0;
        if (ph == 0) chk("m_addr_id", sid_address0, 0);
        if (ph == 1) chk("m_addr_ts", sid_address0, 1);
        chk("m_busy_wait", m_waitrequest0, 1);
        chk("m_busy_rdata", m_readdata0, 0);
      end else begin
        chk("m_id_word", id_word0, m_id);
        chk("m_ts_word", ts_word0, m_ts);
        chk("m_host_addr", sid_address0, m_addr0);
        chk("m_host_wait", m_waitrequest0, start0);
        chk("m_host_rdata", m_readdata0, start0 ? 32'd0 : slv_word(m_addr0, cur_k));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Tick until dut0 reports done; a blown budget is a failed comparison
  task automatic run0(input int n_init, output int n);
    n = n_init;
    while (!done0 && n < 40) begin
      tick();
      n++;
    end
    if (!done0) chk("run0_timeout", done0, 1);
  endtask

  initial begin
    int n;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Boot check: done rises four edges after release
    repeat (3) tick();
    chk("boot_done_early", done0, 0);
    tick();
    chk("boot_done", done0, 1);
    chk("boot_pass", pass0, 1);
    chk("boot_retry", retry0, 0);
    repeat (3) tick();
    chk("boot2_done_early", done2, 0);
    tick();
    chk("boot2_done", done2, 1);
    chk("boot2_pass", pass2, 1);

    // Host read in DONE, zero latency
    m_read0 = 1'b1; m_addr0 = 1'b1;
    #1;
    chk("host_ts_rdata", m_readdata0, 32'd1459342059);
    chk("host_ts_wait", m_waitrequest0, 0);
    m_addr0 = 1'b0;
    #1;
    chk("host_id_rdata", m_readdata0, 32'd0);
    m_read0 = 1'b0;

    // Wrong ID every read: four passes then fail
    bad_id = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    run0(1, n);
    chk("badid_cycles", n, 13);
    chk("badid_retry", retry0, 3);
    chk("badid_fail", fail0, 1);
    chk("badid_pass", pass0, 0);
    chk("badid_id", id_word0, 32'h0000_DEAD);
`ifdef SYSID_CTRL_IRQ_EN
    chk("badid_irq", irq0, 1);
`endif

    // Timestamp wrong on first pass only
    bad_id = 1'b0;
    bad_ts_first = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
`ifdef SYSID_CTRL_IRQ_EN
    chk("irq_cleared", irq0, 0);
`endif
    chk("start_clears_fail", fail0, 0);
    run0(1, n);
    chk("tsfirst_cycles", n, 7);
    chk("tsfirst_retry", retry0, 1);
    chk("tsfirst_pass", pass0, 1);
    chk("tsfirst_ts", ts_word0, 32'd1459342059);
    bad_ts_first = 1'b0;

    // Host read during RD_TS stalls until done; start while busy is ignored
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    m_read0 = 1'b1; m_addr0 = 1'b1; start0 = 1'b1;
    #1;
    chk("rdts_wait", m_waitrequest0, 1);
    chk("rdts_rdata", m_readdata0, 0);
    tick();
    start0 = 1'b0;
    chk("check_wait", m_waitrequest0, 1);
    run0(3, n);
    chk("busy_start_cycles", n, 4);
    chk("after_wait", m_waitrequest0, 0);
    chk("after_rdata", m_readdata0, 32'd1459342059);

    // Start and m_read together in DONE: start wins
    start0 = 1'b1;
    #1;
    chk("start_wins_wait", m_waitrequest0, 1);
    tick();
    start0 = 1'b0;
    run0(1, n);
    chk("start_wins_cycles", n, 4);
    m_read0 = 1'b0; m_addr0 = 1'b0;

    // Reset pulse during RD_TS, then a full rerun
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_addr", sid_address0, 0);
    chk("mid_rst_wait", m_waitrequest0, 1);
    chk("mid_rst_ts", ts_word0, 0);
    tick();
    tick();
    reset_n = 1'b1;
    run0(0, n);
    chk("rerun_cycles", n, 4);
    chk("rerun_pass", pass0, 1);

    // READ_LATENCY=2 instance: address hold, done latency, host stall
    n = 0;
    while (!done2 && n < 40) begin
      tick();
      n++;
    end
    chk("rl2_ready", done2, 1);
    start2 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      start2 = 1'b0;
      if (j <= 3)             chk("rl2_addr_id", sid_address2, 0);
      if (j >= 4 && j <= 6)   chk("rl2_addr_ts", sid_address2, 1);
      if (j == 7)             chk("rl2_done_early", done2, 0);
      if (j == 8) begin
        chk("rl2_done", done2, 1);
        chk("rl2_pass", pass2, 1);
        chk("rl2_ts", ts_word2, 32'd1459342059);
      end
    end
    m_addr2 = 1'b1; m_read2 = 1'b1;
    #1;
    chk("rl2_wait0", m_waitrequest2, 1);
    tick();
    chk("rl2_wait1", m_waitrequest2, 1);
    tick();
    chk("rl2_wait2", m_waitrequest2, 0);
    chk("rl2_rdata", m_readdata2, 32'd1459342059);
    m_read2 = 1'b0;

    tick();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
